// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter that shares one FIFO write port
// between NUM_REQ producers. A grant lasts up to MAX_BURST accepted beats.
// FIFO full stalls the burst without ending it. A FIFO error locks the
// arbiter out until reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick the next requester after the last owner
// ST_BURST | owner granted; one beat per cycle while req and not full
// ST_ERR   | FIFO error seen; no grants or writes until reset
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic [OW-1:0]            owner_o,
  output logic                     busy_o,
  output logic                     err_o,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  input  logic                     fifo_full_i,
  input  logic                     fifo_error_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [OW-1:0]      owner_q;
  logic [3:0]         beat_q;
  logic               err_q;

  logic [OW-1:0]      next_owner_d;
  logic               found_d;
  logic               wr_en;
  logic               last_beat;

  // Round-robin search: first set request strictly after the last owner, wrapping.
  always_comb begin
    int            cand;
    logic [OW-1:0] cand_idx;
    next_owner_d = owner_q;
    found_d      = 1'b0;
    cand         = 0;
    cand_idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(owner_q) + i) % NUM_REQ;
      cand_idx = OW'(cand);
      if (!found_d && req_i[cand_idx]) begin
        found_d      = 1'b1;
        next_owner_d = cand_idx;
      end
    end
  end

  // Owner data mux; follows owner_q in every state so the FIFO sees stable data.
  always_comb begin
    fifo_wdata_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == OW'(k)) begin
        fifo_wdata_o = wdata_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign wr_en        = (state_q == ST_BURST) && req_i[owner_q] && !fifo_full_i;
  assign last_beat    = (beat_q == 4'(MAX_BURST - 1));
  assign fifo_wr_en_o = wr_en;
  assign ack_o        = gnt_q & req_i & {NUM_REQ{~fifo_full_i}};
  assign gnt_o        = gnt_q;
  assign owner_o      = owner_q;
  assign busy_o       = (state_q == ST_BURST);
  assign err_o        = err_q;

  // Arbitration FSM; an error outranks burst completion, reset outranks all.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= OW'(NUM_REQ - 1);
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else if (fifo_error_i) begin
      state_q <= ST_ERR;
      gnt_q   <= '0;
      err_q   <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (found_d) begin
            state_q <= ST_BURST;
            owner_q <= next_owner_d;
            gnt_q   <= NUM_REQ'(1) << next_owner_d;
            beat_q  <= '0;
          end
        end
        ST_BURST: begin
          if (!req_i[owner_q] || (wr_en && last_beat)) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            beat_q  <= '0;
          end else if (wr_en) begin
            beat_q <= beat_q + 4'd1;
          end
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producers with finite data, a reference model of
// the arbitration rules, directed scenarios and a randomized run.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_i = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [N*W-1:0] wdata_i = '0;
  logic           full_i = 1'b0;
  logic           ferr_i = 1'b0;
  logic [N-1:0]   gnt_o, ack_o;
  logic [1:0]     owner_o;
  logic           busy_o, err_o, wr_en_o;
  logic [W-1:0]   wdata_o;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .owner_o(owner_o), .busy_o(busy_o),
    .err_o(err_o), .fifo_wr_en_o(wr_en_o), .fifo_wdata_o(wdata_o),
    .fifo_full_i(full_i), .fifo_error_i(ferr_i)
  );

  int compared = 0;
  int mismatched = 0;

  // producers: beats remaining and next data value per requester
  int           rem[N];
  logic [W-1:0] nxt[N];

  // reference model of the arbitration rules
  bit m_lock, m_active;
  int m_owner, m_beats;

  logic [N-1:0] exp_gnt, exp_ack;
  logic         exp_wr;
  logic [W-1:0] exp_data;
  logic [12:0]  exp_vec, obs;

  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    for (int i = 1; i <= N; i++) begin
      if (req[(last + i) % N]) return (last + i) % N;
    end
    return last;
  endfunction

  // Drive inputs for this cycle, then form model expectations and DUT observation.
  task automatic prep(input logic f, input logic e, input logic r);
    full_i = f;
    ferr_i = e;
    rst_i  = r;
    for (int k = 0; k < N; k++) begin
      req_i[k]           = (rem[k] > 0);
      wdata_i[k*W +: W]  = nxt[k];
    end
    #1;
    exp_wr   = m_active && req_i[m_owner[1:0]] && !f;
    exp_gnt  = m_active ? (4'(1) << m_owner) : 4'b0;
    exp_ack  = exp_wr ? exp_gnt : 4'b0;
    exp_data = nxt[m_owner];
    exp_vec  = {exp_gnt, exp_ack, exp_wr, m_active, m_lock, 2'(m_owner)};
    obs      = {gnt_o, ack_o, wr_en_o, busy_o, err_o, owner_o};
  endtask

  // Clock edge: producers consume accepted beats, model applies the rules.
  task automatic advance();
    @(posedge clk);
    if (exp_wr) begin
      rem[m_owner] = rem[m_owner] - 1;
      nxt[m_owner] = nxt[m_owner] + 8'd1;
    end
    if (!rst_i) begin
      m_lock = 0; m_active = 0; m_owner = N - 1; m_beats = 0;
    end else if (ferr_i) begin
      m_lock = 1; m_active = 0;
    end else if (!m_lock) begin
      if (!m_active) begin
        if (req_i != 0) begin
          m_owner = rr_pick(m_owner, req_i); m_active = 1; m_beats = 0;
        end
      end else if (!req_i[m_owner[1:0]]) begin
        m_active = 0;
      end else if (exp_wr) begin
        m_beats++;
        if (m_beats == MB) m_active = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int k = 0; k < N; k++) begin rem[k] = 0; nxt[k] = '0; end
    prep(1'b0, 1'b0, 1'b0);
    advance();
  endtask

  task automatic test_reset();
    do_reset();
    prep(1'b0, 1'b0, 1'b1);
    compared++;
    if ({gnt_o, wr_en_o, busy_o, err_o, owner_o} !== {4'b0000, 1'b0, 1'b0, 1'b0, 2'd3}) begin
      mismatched++;
      $display("FAIL reset_state: got gnt=%b wr=%b busy=%b err=%b owner=%0d, want 0000/0/0/0/3",
               gnt_o, wr_en_o, busy_o, err_o, owner_o);
    end
    compared++;
    if (obs !== exp_vec) begin
      mismatched++; $display("FAIL reset_model: got %h want %h", obs, exp_vec);
    end
  endtask

  task automatic test_single_burst();
    logic [11:0]  mask = '0;
    logic [W-1:0] wlog[$];
    do_reset();
    rem[0] = 6; nxt[0] = 8'h11;
    for (int c = 0; c < 12; c++) begin
      prep(1'b0, 1'b0, 1'b1);
      compared++;
      if (obs !== exp_vec || (exp_wr && wdata_o !== exp_data)) begin
        mismatched++;
        $display("FAIL single_burst c%0d: got %h/%h want %h/%h", c, obs, wdata_o, exp_vec, exp_data);
      end
      if (wr_en_o) begin mask[c] = 1'b1; wlog.push_back(wdata_o); end
      advance();
    end
    compared++;
    if (mask !== 12'h0DE) begin
      mismatched++; $display("FAIL single_burst_cycles: got %h want 0de", mask);
    end
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (i >= wlog.size() || wlog[i] !== 8'(8'h11 + i)) begin
        mismatched++;
        $display("FAIL single_burst_data%0d: got %h want %h", i,
                 (i < wlog.size()) ? wlog[i] : 8'hxx, 8'(8'h11 + i));
      end
    end
  endtask

  task automatic test_round_robin();
    int           nwr = 0;
    int           starts[$];
    int           owners[$];
    logic [N-1:0] prev = '0;
    do_reset();
    for (int k = 0; k < N; k++) begin rem[k] = 1000; nxt[k] = 8'(k * 32); end
    for (int c = 0; c < 25; c++) begin
      prep(1'b0, 1'b0, 1'b1);
      compared++;
      if (obs !== exp_vec || (exp_wr && wdata_o !== exp_data)) begin
        mismatched++;
        $display("FAIL round_robin c%0d: got %h/%h want %h/%h", c, obs, wdata_o, exp_vec, exp_data);
      end
      if (wr_en_o) nwr++;
      if (prev == 0 && gnt_o != 0) begin
        starts.push_back(c);
        for (int k = 0; k < N; k++) if (gnt_o[k]) owners.push_back(k);
      end
      prev = gnt_o;
      advance();
    end
    compared++;
    if (nwr != 20) begin mismatched++; $display("FAIL rr_writes: got %0d want 20", nwr); end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (i >= owners.size() || owners[i] != (i % N) || starts[i] != 1 + 5 * i) begin
        mismatched++;
        $display("FAIL rr_grant%0d: got owner=%0d at=%0d want owner=%0d at=%0d", i,
                 (i < owners.size()) ? owners[i] : -1, (i < starts.size()) ? starts[i] : -1,
                 i % N, 1 + 5 * i);
      end
    end
  endtask

  task automatic test_full_stall();
    int nwr = 0;
    do_reset();
    rem[2] = 10; nxt[2] = 8'h40;
    for (int c = 0; c < 10; c++) begin
      prep(c >= 3 && c <= 5, 1'b0, 1'b1);
      compared++;
      if (obs !== exp_vec || (exp_wr && wdata_o !== exp_data)) begin
        mismatched++;
        $display("FAIL full_stall c%0d: got %h/%h want %h/%h", c, obs, wdata_o, exp_vec, exp_data);
      end
      if (c >= 3 && c <= 5) begin
        compared++;
        if (gnt_o !== 4'b0100 || wr_en_o !== 1'b0) begin
          mismatched++;
          $display("FAIL full_hold c%0d: got gnt=%b wr=%b want 0100/0", c, gnt_o, wr_en_o);
        end
      end
      if (c == 8) begin
        compared++;
        if (nwr != 4 || gnt_o !== 4'b0000) begin
          mismatched++;
          $display("FAIL full_burst_end: got writes=%0d gnt=%b want 4/0000", nwr, gnt_o);
        end
      end
      if (wr_en_o) nwr++;
      advance();
    end
  endtask

  task automatic test_drop_req();
    logic [N-1:0] gh[6];
    do_reset();
    rem[1] = 1; nxt[1] = 8'h51;
    rem[3] = 10; nxt[3] = 8'h70;
    for (int c = 0; c < 6; c++) begin
      prep(1'b0, 1'b0, 1'b1);
      compared++;
      if (obs !== exp_vec || (exp_wr && wdata_o !== exp_data)) begin
        mismatched++;
        $display("FAIL drop_req c%0d: got %h/%h want %h/%h", c, obs, wdata_o, exp_vec, exp_data);
      end
      gh[c] = gnt_o;
      advance();
    end
    compared++;
    if ({gh[1], gh[2], gh[3], gh[4]} !== {4'b0010, 4'b0010, 4'b0000, 4'b1000}) begin
      mismatched++;
      $display("FAIL drop_req_grants: got %b %b %b %b want 0010 0010 0000 1000",
               gh[1], gh[2], gh[3], gh[4]);
    end
  endtask

  task automatic test_error();
    int nwr = 0;
    do_reset();
    for (int k = 0; k < N; k++) begin rem[k] = 100; nxt[k] = 8'(8'h80 + k * 16); end
    for (int c = 0; c < 13; c++) begin
      prep(1'b0, c == 2, c != 10);
      compared++;
      if (obs !== exp_vec || (exp_wr && wdata_o !== exp_data)) begin
        mismatched++;
        $display("FAIL error c%0d: got %h/%h want %h/%h", c, obs, wdata_o, exp_vec, exp_data);
      end
      if (c >= 3 && c <= 10 && wr_en_o) nwr++;
      if (c == 3) begin
        compared++;
        if (err_o !== 1'b1 || gnt_o !== 4'b0000) begin
          mismatched++; $display("FAIL error_lock: got err=%b gnt=%b want 1/0000", err_o, gnt_o);
        end
      end
      if (c == 12) begin
        compared++;
        if (err_o !== 1'b0 || gnt_o !== 4'b0001) begin
          mismatched++; $display("FAIL error_restart: got err=%b gnt=%b want 0/0001", err_o, gnt_o);
        end
      end
      advance();
    end
    compared++;
    if (nwr != 0) begin mismatched++; $display("FAIL error_writes: got %0d want 0", nwr); end
  endtask

  task automatic test_reset_mid_burst();
    int nwr = 0;
    do_reset();
    rem[3] = 50; nxt[3] = 8'hA0;
    for (int c = 0; c < 10; c++) begin
      prep(1'b0, 1'b0, c != 3);
      compared++;
      if (obs !== exp_vec || (exp_wr && wdata_o !== exp_data)) begin
        mismatched++;
        $display("FAIL reset_mid c%0d: got %h/%h want %h/%h", c, obs, wdata_o, exp_vec, exp_data);
      end
      if (c == 4) begin
        compared++;
        if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin
          mismatched++; $display("FAIL reset_mid_drop: got gnt=%b busy=%b want 0000/0", gnt_o, busy_o);
        end
      end
      if (c >= 5 && wr_en_o) nwr++;
      advance();
    end
    compared++;
    if (nwr != 4) begin mismatched++; $display("FAIL reset_mid_fresh: got %0d writes want 4", nwr); end
  endtask

  task automatic test_random();
    logic f, e, r;
    do_reset();
    for (int k = 0; k < N; k++) nxt[k] = 8'($urandom);
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (rem[k] == 0 && $urandom_range(0, 5) == 0) rem[k] = $urandom_range(1, 9);
      end
      f = ($urandom_range(0, 3) == 0);
      e = ($urandom_range(0, 149) == 0);
      r = !((m_lock && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0);
      prep(f, e, r);
      compared++;
      if (obs !== exp_vec || (exp_wr && wdata_o !== exp_data)) begin
        mismatched++;
        $display("FAIL random c%0d: got %h/%h want %h/%h", c, obs, wdata_o, exp_vec, exp_data);
      end
      advance();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_drop_req();
    test_error();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port (wr_en/wdata/full/error) between NUM_REQ producers.
- Grants ownership in bursts of up to MAX_BURST beats and stalls on FIFO full.
- Latches FIFO write errors into a sticky lockout state.
- Sits directly in front of the FIFO write side; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data width; equals the FIFO data width.
- MAX_BURST, 4, maximum beats per grant (1..15).

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset; synchronous, active-low.
- req_i  input  NUM_REQ  per-requester write request; the requester holds it while it has data.
- wdata_i  input  NUM_REQ*WIDTH  packed data; requester k occupies bits [k*WIDTH +: WIDTH].
- gnt_o  output  NUM_REQ  registered one-hot owner grant; all zero when no owner.
- ack_o  output  NUM_REQ  combinational per-beat accept: gnt_o & req_i & ~full_i; the requester advances its data on ack.
- owner_o  output  clog2(NUM_REQ)  index of the current or last owner.
- busy_o  output  1  high in BURST state.
- err_o  output  1  sticky error flag.
- fifo_wr_en_o  output  1  FIFO write enable.
- fifo_wdata_o  output  WIDTH  FIFO write data.
- fifo_full_i  input  1  FIFO full flag.
- fifo_error_i  input  1  FIFO error flag.

Behaviour:
- Reset (rst_i==0 at a clock edge), synchronous, overrides everything:
  - state=IDLE, gnt_o=0, owner_o=NUM_REQ-1 so requester 0 wins first, beat_cnt=0, busy_o=0, err_o=0.
  - fifo_wr_en_o=0; fifo_wdata_o follows the owner mux (value 0 is not required).
  - Reset mid-burst drops the grant at that edge and discards no already-written beat.
- States: IDLE, BURST, ERR.
- IDLE:
  - If any req_i bit is set, select the first set bit searching upward from owner_o+1, wrapping mod NUM_REQ.
  - Register owner_o, set gnt_o one-hot, beat_cnt=0, go to BURST.
  - Arbitration costs exactly one cycle: req at edge n gives gnt at edge n+1, first write possible in the cycle after edge n+1.
  - If no req_i bit is set, stay in IDLE with gnt_o=0.
- BURST:
  - fifo_wr_en_o = req_i[owner] & ~fifo_full_i, combinational.
  - fifo_wdata_o = wdata_i[owner slice].
  - Each cycle with fifo_wr_en_o=1: beat_cnt += 1.
  - Exit to IDLE, clearing gnt_o at that edge, when either:
    - req_i[owner]==0 at an edge, or
    - a write occurs with beat_cnt==MAX_BURST-1, i.e. the MAX_BURST-th beat.
  - One idle bubble follows every burst. The next search starts after the just-finished owner, so one requester cannot starve the others.
  - fifo_full_i==1: no write, grant held, beat_cnt frozen. A full stall never ends a burst.
- ERR:
  - Entered from any non-reset state on the edge where fifo_error_i==1.
  - err_o=1, gnt_o=0, fifo_wr_en_o=0, all req_i ignored.
  - Left only by reset.
- Simultaneous events:
  - fifo_error_i takes priority over burst completion.
  - A beat written in the same cycle that error rises is still counted as written.
- Non-owner requesters never see ack_o.
- ack_o equals fifo_wr_en_o routed to the owner bit.
- Invariants:
  - gnt_o is always 0 or one-hot.
  - A write never occurs while fifo_full_i==1.

Test Plan:
- Reset, then req_i=4'b0001 with data 0x11..0x16 (6 beats) and the FIFO not full -> gnt_o=0001 one cycle after req; beats 0x11–0x14 written on 4 consecutive cycles; gnt drops; one bubble; re-grant to 0; 0x15, 0x16 written; then IDLE.
- req_i=4'b1111 held continuously, MAX_BURST=4 -> grant order 0,1,2,3,0; each burst writes 4 beats; each burst is separated by exactly one idle cycle.
- Owner 2 mid-burst after 2 beats, fifo_full_i=1 for 3 cycles -> fifo_wr_en_o=0 and gnt_o=0100 held for 3 cycles; beat_cnt stays 2; full drops -> 2 more beats, then the burst ends.
- Owner 1 drops req_i[1] after 1 beat while req_i[3]=1 -> IDLE for 1 cycle; then gnt_o=1000.
- fifo_error_i pulses for 1 cycle during a burst -> next edge err_o=1 and gnt_o=0; with req_i=4'b1111 no further writes; rst_i=0 for 1 cycle clears err_o and restarts arbitration at requester 0.
- rst_i=0 asserted mid-burst (beat 2 of owner 3) -> at that edge gnt_o=0, busy_o=0; after release with req_i=4'b1000, requester 3 is granted with a fresh beat_cnt of 0.
